// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment scan controller.
// Holds FSM state encodings, blanking values and anode selects.
package disp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SHOW = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  function automatic logic [3:0] anode_sel(
    input logic [1:0] idx
  );
    logic [3:0] an;
    an = ANODE_OFF;
    unique case (idx)
      2'd0: an = AN_DIG0;
      2'd1: an = AN_DIG1;
      2'd2: an = AN_DIG2;
      2'd3: an = AN_DIG3;
      default: an = ANODE_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg7_font.sv
// Hex nibble to active-low 7-segment pattern.
// Output bit order is {g,f,e,d,c,b,a}.
module seg7_font (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    unique case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit common-anode scan controller with double-buffered value.
// Define DISP_LZ_BLANK_EN to blank leading zero digits.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int PRESCALE   = 50000,
  parameter int GAP_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        load_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int CNT_MAX =
    (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [CW-1:0] SHOW_LAST =
    CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   shadow_val_q, shadow_val_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [15:0]   active_val_q, active_val_d;
  logic [3:0]    active_dp_q, active_dp_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          wrap;
  logic [3:0]    nib;
  logic [6:0]    font_seg;
  logic          blank;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    wrap    = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          state_d = ST_SHOW;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
        (state_q == ST_SHOW): begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (HAS_GAP) begin
              state_d = ST_GAP;
            end else begin
              idx_d = idx_q + 2'd1;
              wrap  = (idx_q == 2'd3);
            end
          end
        end
        (state_q == ST_GAP): begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = ST_SHOW;
            idx_d   = idx_q + 2'd1;
            wrap    = (idx_q == 2'd3);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A load coinciding with a wrap lands in shadow after active took the old one.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    if (wrap && pending_q) begin
      active_val_d = shadow_val_q;
      active_dp_d  = shadow_dp_q;
      pending_d    = 1'b0;
    end
    if (load_i) begin
      shadow_val_d = value_i;
      shadow_dp_d  = dp_i;
      pending_d    = 1'b1;
    end
  end

  always_comb begin
    nib = 4'h0;
    unique case (idx_q)
      2'd0: nib = active_val_q[3:0];
      2'd1: nib = active_val_q[7:4];
      2'd2: nib = active_val_q[11:8];
      2'd3: nib = active_val_q[15:12];
      default: nib = 4'h0;
    endcase
  end

  seg7_font u_font (
    .nibble_i (nib),
    .seg_o    (font_seg)
  );

`ifdef DISP_LZ_BLANK_EN
  logic z3, z2, z1;
  logic [3:0] lz;
  assign z3 = (active_val_q[15:12] == 4'h0);
  assign z2 = (active_val_q[11:8] == 4'h0);
  assign z1 = (active_val_q[7:4] == 4'h0);
  assign lz = {z3, z3 & z2, z3 & z2 & z1, 1'b0};
  assign blank = lz[idx_q];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d  = ANODE_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == ST_SHOW) begin
      an_d  = anode_sel(idx_q);
      seg_d = blank ? SEG_OFF : font_seg;
      dp_d  = ~active_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= ANODE_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = wrap;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (PRESCALE=4, GAP_CYCLES=2).
// Output bundle compared as {an_o, seg_o, dp_o, frame_o}.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable_i = 1'b0;
  logic [15:0] value_i = 16'h0;
  logic [3:0]  dp_i = 4'h0;
  logic        load_i = 1'b0;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  int checks = 0;
  int failures = 0;

`ifdef DISP_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam logic [6:0] Z_SEG = LZ ? 7'h7F : 7'h40;
  localparam logic [12:0] DARK = {4'b1111, 7'h7F, 1'b1, 1'b0};

  logic [12:0] outs;
  assign outs = {an_o, seg_o, dp_o, frame_o};

  display_scan_ctrl #(
    .PRESCALE   (4),
    .GAP_CYCLES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable_i),
    .value_i  (value_i),
    .dp_i     (dp_i),
    .load_i   (load_i),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .dp_o     (dp_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (frame_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== DARK) begin
      failures++;
      $display("FAIL reset_vals got=%b exp=%b", outs, DARK);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checks++;
      if (outs !== DARK) begin
        failures++;
        $display("FAIL idle_dark cyc=%0d got=%b exp=%b", i, outs, DARK);
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0]  seg1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0]  ansel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [12:0] exp;
    int p, d;
    enable_i = 1'b1;
    load_i   = 1'b1;
    value_i  = 16'h1234;
    dp_i     = 4'h0;
    for (int k = 1; k <= 49; k++) begin
      tick(1);
      load_i = 1'b0;
      exp = DARK;
      if (k >= 2) begin
        p = (k - 2) % 24;
        d = p / 6;
        if ((p % 6) < 4) begin
          exp[12:9] = ansel[d];
          exp[8:2]  = ((k - 2) / 24 == 0) ? 7'h40 : seg1234[d];
        end
      end
      exp[0] = ((k % 24) == 0);
      checks++;
      if (outs !== exp) begin
        failures++;
        $display("FAIL scan k=%0d got=%b exp=%b", k, outs, exp);
      end
    end
  endtask

  task automatic test_load_on_frame();
    bit ok;
    logic [12:0] exp [4];
    exp = '{{4'b1110, 7'h21, 1'b1, 1'b0}, {4'b1101, 7'h46, 1'b1, 1'b0},
            {4'b1011, 7'h03, 1'b1, 1'b0}, {4'b0111, 7'h08, 1'b1, 1'b0}};
    wait_frame(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_timeout_a got=0 exp=1");
    end
    load_i  = 1'b1;
    value_i = 16'hABCD;
    tick(1);
    load_i = 1'b0;
    tick(1);
    checks++;
    if (outs !== {4'b1110, 7'h19, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL no_early_commit got=%b exp=%b", outs,
               {4'b1110, 7'h19, 1'b1, 1'b0});
    end
    wait_frame(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_timeout_b got=0 exp=1");
    end
    for (int n = 0; n < 4; n++) begin
      tick(n == 0 ? 2 : 6);
      checks++;
      if (outs !== exp[n]) begin
        failures++;
        $display("FAIL abcd_dig%0d got=%b exp=%b", n, outs, exp[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    load_i  = 1'b1;
    value_i = 16'h1111;
    tick(1);
    load_i = 1'b0;
    tick(1);
    load_i  = 1'b1;
    value_i = 16'h2222;
    tick(1);
    load_i = 1'b0;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_timeout_c got=0 exp=1");
    end
    tick(2);
    checks++;
    if (outs !== {4'b1110, 7'h24, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL last_load_dig0 got=%b exp=%b", outs,
               {4'b1110, 7'h24, 1'b1, 1'b0});
    end
    tick(18);
    checks++;
    if (outs !== {4'b0111, 7'h24, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL last_load_dig3 got=%b exp=%b", outs,
               {4'b0111, 7'h24, 1'b1, 1'b0});
    end
  endtask

  task automatic test_enable();
    bit ok;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_timeout_d got=0 exp=1");
    end
    tick(14);
    checks++;
    if (outs !== {4'b1011, 7'h24, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL dig2_show got=%b exp=%b", outs,
               {4'b1011, 7'h24, 1'b1, 1'b0});
    end
    enable_i = 1'b0;
    tick(1);
    checks++;
    if (outs !== {4'b1011, 7'h24, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL dis_lag got=%b exp=%b", outs,
               {4'b1011, 7'h24, 1'b1, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if (outs !== DARK) begin
        failures++;
        $display("FAIL dis_dark i=%0d got=%b exp=%b", i, outs, DARK);
      end
    end
    enable_i = 1'b1;
    tick(1);
    checks++;
    if (outs !== DARK) begin
      failures++;
      $display("FAIL reen_lag got=%b exp=%b", outs, DARK);
    end
    tick(1);
    checks++;
    if (outs !== {4'b1110, 7'h24, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reen_dig0 got=%b exp=%b", outs,
               {4'b1110, 7'h24, 1'b1, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    load_i  = 1'b1;
    value_i = 16'h5678;
    tick(1);
    load_i = 1'b0;
    tick(2);
    checks++;
    if (outs !== {4'b1110, 7'h24, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL pre_rst got=%b exp=%b", outs,
               {4'b1110, 7'h24, 1'b1, 1'b0});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== DARK) begin
      failures++;
      $display("FAIL async_rst got=%b exp=%b", outs, DARK);
    end
    @(negedge clk) rst_n = 1'b1;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_timeout_e got=0 exp=1");
    end
    tick(2);
    checks++;
    if (outs !== {4'b1110, 7'h40, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL pending_lost got=%b exp=%b", outs,
               {4'b1110, 7'h40, 1'b1, 1'b0});
    end
  endtask

  task automatic test_leading_zero();
    bit ok;
    logic [12:0] e50 [4];
    logic [12:0] e00 [4];
    e50 = '{{4'b1110, 7'h40, 1'b1, 1'b0}, {4'b1101, 7'h12, 1'b1, 1'b0},
            {4'b1011, Z_SEG, 1'b1, 1'b0}, {4'b0111, Z_SEG, 1'b0, 1'b0}};
    e00 = '{{4'b1110, 7'h40, 1'b1, 1'b0}, {4'b1101, Z_SEG, 1'b1, 1'b0},
            {4'b1011, Z_SEG, 1'b1, 1'b0}, {4'b0111, Z_SEG, 1'b1, 1'b0}};
    load_i  = 1'b1;
    value_i = 16'h0050;
    dp_i    = 4'b1000;
    tick(1);
    load_i = 1'b0;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_timeout_f got=0 exp=1");
    end
    for (int n = 0; n < 4; n++) begin
      tick(n == 0 ? 2 : 6);
      checks++;
      if (outs !== e50[n]) begin
        failures++;
        $display("FAIL v0050_dig%0d got=%b exp=%b", n, outs, e50[n]);
      end
    end
    load_i  = 1'b1;
    value_i = 16'h0000;
    dp_i    = 4'b0000;
    tick(1);
    load_i = 1'b0;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_timeout_g got=0 exp=1");
    end
    for (int n = 0; n < 4; n++) begin
      tick(n == 0 ? 2 : 6);
      checks++;
      if (outs !== e00[n]) begin
        failures++;
        $display("FAIL v0000_dig%0d got=%b exp=%b", n, outs, e00[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_on_frame();
    test_back_to_back();
    test_enable();
    test_async_reset();
    test_leading_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
